// File: rtl/jtframe_frame_sig.sv
// Per-frame MISR signature and active-pixel count of the core's pixel stream, one record per frame after a skip window.
// Latency: sig/pxl_total/sig_valid one clk after the vb rising edge; observe-only, so no backpressure.
module jtframe_frame_sig #(
    parameter int CW      = 4,
    parameter int SIGW    = 32,
    parameter     POLY    = 32'h04C1_1DB7,
    parameter     SEED    = 32'hFFFF_FFFF,
    parameter int SKIP    = 0,
    parameter int NFRAMES = 0,
    parameter int PCW     = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pxl_cen,
    input  logic            hb,
    input  logic            vb,
    input  logic [CW-1:0]   red,
    input  logic [CW-1:0]   green,
    input  logic [CW-1:0]   blue,
    input  logic            dwnld_busy,
    output logic [31:0]     frame_cnt,
    output logic [SIGW-1:0] sig,
    output logic [PCW-1:0]  pxl_total,
    output logic            sig_valid,
    output logic            done
);

    localparam int SKW = (SKIP > 0)    ? $clog2(SKIP + 1)    : 1;
    localparam int RPW = (NFRAMES > 0) ? $clog2(NFRAMES + 1) : 1;

    localparam logic [SIGW-1:0] L_POLY = SIGW'(POLY);
    localparam logic [SIGW-1:0] L_SEED = SIGW'(SEED);
    localparam logic [SKW-1:0]  L_SKIP = SKW'(SKIP);
    localparam logic [RPW-1:0]  L_NF   = RPW'(NFRAMES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_vb_l;
    logic [SIGW-1:0] r_acc;
    logic [PCW-1:0]  r_pix;
    logic [SKW-1:0]  r_skip;
    logic [RPW-1:0]  r_rep;
    logic [31:0]     r_frame_cnt;
    logic [SIGW-1:0] r_sig;
    logic [PCW-1:0]  r_pxl_total;
    logic            r_sig_valid;
    logic            r_done;

    logic            w_vb_rise;
    logic            w_active;
    logic [SIGW-1:0] w_pix_ext;
    logic [SIGW-1:0] w_acc_nxt;
    logic [RPW-1:0]  w_rep_inc;

    logic            w_clear;
    logic            w_clr_ctr;
    logic            w_step;
    logic            w_frame_inc;
    logic            w_skip_inc;
    logic            w_report;
    logic            w_enter_done;

    assign w_vb_rise = vb & ~r_vb_l;
    assign w_active  = pxl_cen & ~hb & ~vb;
    assign w_pix_ext = SIGW'({red, green, blue});
    assign w_acc_nxt = {r_acc[SIGW-2:0], 1'b0}
                     ^ (r_acc[SIGW-1] ? L_POLY : {SIGW{1'b0}})
                     ^ w_pix_ext;
    assign w_rep_inc = r_rep + 1'b1;

    always_comb begin
        w_next       = r_state;
        w_clear      = 1'b0;
        w_clr_ctr    = 1'b0;
        w_step       = 1'b0;
        w_frame_inc  = 1'b0;
        w_skip_inc   = 1'b0;
        w_report     = 1'b0;
        w_enter_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clear   = 1'b1;
                w_clr_ctr = 1'b1;
                if (!dwnld_busy) begin
                    w_next = S_SYNC;
                end
            end
            S_SYNC: begin
                if (dwnld_busy) begin
                    w_next    = S_IDLE;
                    w_clear   = 1'b1;
                    w_clr_ctr = 1'b1;
                end else if (w_vb_rise) begin
                    // the partial frame seen before this edge is dropped uncounted
                    w_next    = S_RUN;
                    w_clear   = 1'b1;
                    w_clr_ctr = 1'b1;
                end
            end
            S_RUN: begin
                if (dwnld_busy) begin
                    w_next    = S_IDLE;
                    w_clear   = 1'b1;
                    w_clr_ctr = 1'b1;
                end else if (w_vb_rise) begin
                    w_frame_inc = 1'b1;
                    w_clear     = 1'b1;
                    if (r_skip < L_SKIP) begin
                        w_skip_inc = 1'b1;
                    end else begin
                        w_report = 1'b1;
                        if ((NFRAMES != 0) && (w_rep_inc == L_NF)) begin
                            w_next       = S_DONE;
                            w_enter_done = 1'b1;
                        end
                    end
                end else if (w_active) begin
                    w_step = 1'b1;
                end
            end
            S_DONE: begin
                if (dwnld_busy) begin
                    w_next    = S_IDLE;
                    w_clear   = 1'b1;
                    w_clr_ctr = 1'b1;
                end else if (w_vb_rise) begin
                    w_frame_inc = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_vb_l      <= 1'b0;
            r_acc       <= L_SEED;
            r_pix       <= '0;
            r_skip      <= '0;
            r_rep       <= '0;
            r_frame_cnt <= '0;
            r_sig       <= '0;
            r_pxl_total <= '0;
            r_sig_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_vb_l      <= vb;
            r_sig_valid <= w_report;

            if (w_frame_inc) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end

            if (w_clear) begin
                r_acc <= L_SEED;
                r_pix <= '0;
            end else if (w_step) begin
                r_acc <= w_acc_nxt;
                if (~&r_pix) begin
                    r_pix <= r_pix + 1'b1;
                end
            end

            if (w_clr_ctr) begin
                r_skip <= '0;
                r_rep  <= '0;
            end else begin
                if (w_skip_inc) begin
                    r_skip <= r_skip + 1'b1;
                end
                if (w_report && ~&r_rep) begin
                    r_rep <= w_rep_inc;
                end
            end

            if (w_report) begin
                r_sig       <= r_acc;
                r_pxl_total <= r_pix;
            end

            if (w_enter_done) begin
                r_done <= 1'b1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign sig       = r_sig;
    assign pxl_total = r_pxl_total;
    assign sig_valid = r_sig_valid;
    assign done      = r_done;

endmodule

// File: doc/jtframe_frame_sig.md
Name: jtframe_frame_sig

Overview:
- Parametrised successor to the frame-dump/frame-count monitor.
- Watches the core's native pixel stream (pxl_cen, hb, vb, RGB) and counts frames.
- Compresses every active pixel of each frame into a MISR signature and counts active pixels per frame.
- Emits one signature record per frame after a configurable skip window. Sits beside the game core in sim and on-chip, so regressions can compare per-frame signatures instead of full dumps.

Parameters:
- CW, 4, bits per colour channel; pixel word is {red,green,blue} = 3*CW bits.
- SIGW, 32, signature width; requires 3*CW <= SIGW.
- POLY, 32'h04C1_1DB7, MISR feedback polynomial (SIGW bits).
- SEED, 32'hFFFF_FFFF, signature value loaded at the start of each frame.
- SKIP, 0, frames after sync to discard (no sig_valid).
- NFRAMES, 0, frames to report after skip; 0 = unlimited.
- PCW, 20, pixel-counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pxl_cen  in  1  pixel clock enable.
- hb  in  1  horizontal blank, active high.
- vb  in  1  vertical blank, active high.
- red  in  CW  red channel.
- green  in  CW  green channel.
- blue  in  CW  blue channel.
- dwnld_busy  in  1  ROM download/conversion in progress; monitor is held idle.
- frame_cnt  out  32  frames seen since sync (vb rising edges), wraps.
- sig  out  SIGW  signature of last reported frame.
- pxl_total  out  PCW  active pixels in last reported frame.
- sig_valid  out  1  one-cycle strobe: sig/pxl_total updated.
- done  out  1  NFRAMES reported; sticky until rst.

Behaviour:
- Reset: all outputs 0, state IDLE, accumulator = SEED, pixel counter = 0, vb_l = 0.
- vb_l registers vb every clk (not gated by pxl_cen). vb_rise = vb & ~vb_l.
- Active pixel: pxl_cen & ~hb & ~vb.
- MISR step on an active pixel: acc <= {acc[SIGW-2:0],1'b0} ^ (acc[SIGW-1] ? POLY : 0) ^ zero-extended {red,green,blue}. Pixel counter +1, saturating at all-ones.
- States:
  - IDLE: while dwnld_busy=1, stay. When dwnld_busy=0, go to SYNC.
  - SYNC: discard pixels until vb_rise. On vb_rise: acc<=SEED, pixel counter<=0, skip counter<=0, then go to RUN. frame_cnt is not incremented (the partial frame is dropped).
  - RUN: accumulate active pixels. On vb_rise:
    - frame_cnt+1.
    - If skip counter < SKIP: skip counter+1, no strobe.
    - Else: sig<=acc, pxl_total<=pixel counter, sig_valid=1 next cycle, report counter+1.
    - acc<=SEED and pixel counter<=0 in the same cycle.
    - If NFRAMES!=0 and report counter reaches NFRAMES: go to DONE.
  - DONE: done=1; frame_cnt still increments on vb_rise; no further strobes or accumulation.
- Latency: sig/pxl_total/sig_valid valid 1 clk after the vb_rise cycle. sig_valid is exactly 1 cycle wide. sig and pxl_total hold between strobes.
- An active pixel cannot coincide with vb_rise, since vb=1 in that cycle.
- dwnld_busy rising in any state except IDLE: next cycle go to IDLE, reset acc/counters/skip/report counter, drop the in-progress frame. frame_cnt, sig, pxl_total and done hold.
- rst at any time overrides everything, including mid-frame and in DONE.
- frame_cnt wraps 0xFFFF_FFFF->0. Skip and report counters are sized to their parameters and do not wrap.
- Only SIGW low bits of POLY/SEED are used.

Test Plan:
1. CW=4,SIGW=16,POLY=16'h1021,SEED=0,SKIP=0: sync, then a frame with one active pixel RGB=0,0,1 then vb_rise -> one cycle later sig=0x0001, pxl_total=1, sig_valid high 1 clk, frame_cnt=1.
2. Same config, frame pixels 0x001 then 0x002 -> sig=0x0000, pxl_total=2. With SEED=16'h8000 and one pixel 0x000 -> sig=0x1021.
3. SKIP=2,NFRAMES=3, 6 identical frames of 100 pixels -> sig_valid on frames 3,4,5 only, pxl_total=100 each, done=1 after frame 5, frame_cnt=6 at end.
4. dwnld_busy=1 for 50 frames -> no strobes, frame_cnt=0. Release -> first partial frame dropped, first strobe at the second vb_rise.
5. Assert dwnld_busy mid-frame after 40 pixels, release, run a full frame of 10 pixels -> reported pxl_total=10, and sig matches the reference for those 10 pixels only.
6. Pixels toggling with pxl_cen=0 or hb=1 -> ignored (pxl_total unchanged). rst asserted in DONE -> all outputs 0 next cycle.
